tl_log_buffer: RTL and testbench

//  Parametrised TileLink transaction logger: captures beats from NUM_CH channels (A..E)
//  and timestamps them with an internal cycle counter. Each channel has a 1-entry stage;
//  a round-robin arbiter moves staged records into a DEPTH-entry FIFO. The FIFO is drained

---
 rtl/tl_log_pkg.sv | 36 +++
 rtl/tl_log_fifo.sv | 61 ++++++
 rtl/tl_log_buffer.sv | 175 +++++++++++++++++
 tb/tb_tl_log_buffer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_log_pkg.sv
// Shared layout of a TileLink log record: field widths, channel codes and offsets.
package tl_log_pkg;

    localparam int CH_FIELD_W = 3;
    localparam int TL_BYTE_W  = 8;

    typedef enum logic [CH_FIELD_W-1:0] {
        CH_A = 3'd0,
        CH_B = 3'd1,
        CH_C = 3'd2,
        CH_D = 3'd3,
        CH_E = 3'd4
    } tl_channel_e;

    // Record is {stamp, channel, opcode, param, source, sink, address, data}, data at bit 0.
    function automatic int rec_w(input int addr_w, input int data_w, input int stamp_w);
        return stamp_w + CH_FIELD_W + 4 * TL_BYTE_W + addr_w + data_w;
    endfunction

    function automatic int sink_lsb(input int addr_w, input int data_w);
        return data_w + addr_w;
    endfunction

    function automatic int opcode_lsb(input int addr_w, input int data_w);
        return sink_lsb(addr_w, data_w) + 3 * TL_BYTE_W;
    endfunction

    function automatic int chan_lsb(input int addr_w, input int data_w);
        return sink_lsb(addr_w, data_w) + 4 * TL_BYTE_W;
    endfunction

    function automatic int stamp_lsb(input int addr_w, input int data_w);
        return chan_lsb(addr_w, data_w) + CH_FIELD_W;
    endfunction

endpackage

// File: rtl/tl_log_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module tl_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     head_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign head_valid = (count_q != '0);
    assign full       = (count_q == (AW+1)'(DEPTH));
    assign pop_ok     = pop && head_valid;
    assign push_ok    = push && (!full || pop_ok);
    assign head       = mem[rd_ptr];
    assign count      = count_q;

    // Pointers are exactly AW bits so they wrap on their own at DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/tl_log_buffer.sv
// TileLink transaction logger: per-channel one-entry stages, round-robin arbiter
// into a log FIFO, free-running timestamp and saturating drop counter.
module tl_log_buffer
    import tl_log_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 256,
    parameter int STAMP_W = 64,
    parameter int DROP_W  = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   en,
    input  logic [NUM_CH-1:0]                      in_valid,
    input  logic [NUM_CH*8-1:0]                    in_opcode,
    input  logic [NUM_CH*8-1:0]                    in_param,
    input  logic [NUM_CH*8-1:0]                    in_source,
    input  logic [NUM_CH*8-1:0]                    in_sink,
    input  logic [NUM_CH*ADDR_W-1:0]               in_address,
    input  logic [NUM_CH*DATA_W-1:0]               in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [rec_w(ADDR_W, DATA_W, STAMP_W)-1:0] out_record,
    output logic [$clog2(DEPTH):0]                 fifo_count,
    output logic [DROP_W-1:0]                      drop_count,
    output logic [STAMP_W-1:0]                     stamp_now
);

    localparam int REC_W  = rec_w(ADDR_W, DATA_W, STAMP_W);
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DSUM_W = DROP_W + 4;

    logic [STAMP_W-1:0] stamp_q;
    logic [DROP_W-1:0]  drop_q;
    logic [DROP_W-1:0]  drop_next;
    logic [DSUM_W-1:0]  drop_wide;
    logic [3:0]         drop_sum;

    logic [NUM_CH-1:0]  stage_full;
    logic [REC_W-1:0]   stage_rec [NUM_CH];
    logic [REC_W-1:0]   cap_rec   [NUM_CH];
    logic [NUM_CH-1:0]  load_vec;
    logic [NUM_CH-1:0]  grant_vec;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;

    logic               push;
    logic [REC_W-1:0]   push_rec;
    logic               pop;
    logic               fifo_full;
    logic               fifo_room;

    assign stamp_now  = stamp_q;
    assign drop_count = drop_q;
    assign pop        = out_valid && out_ready;
    assign fifo_room  = !fifo_full || pop;
    assign push       = grant_any && fifo_room;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cap
        assign cap_rec[c] = {stamp_q,
                             CH_FIELD_W'(c),
                             in_opcode[c*8 +: 8],
                             in_param[c*8 +: 8],
                             in_source[c*8 +: 8],
                             in_sink[c*8 +: 8],
                             in_address[c*ADDR_W +: ADDR_W],
                             in_data[c*DATA_W +: DATA_W]};
    end

    // First pass finds the lowest full stage (the wrap-around choice); the second
    // overrides it with the lowest full stage at or above the round-robin pointer.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (stage_full[c]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(c);
            end
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (stage_full[c] && (c >= int'(rr_ptr))) begin
                grant_idx = PTR_W'(c);
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        push_rec  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (push && (grant_idx == PTR_W'(c))) begin
                grant_vec[c] = 1'b1;
                push_rec     = stage_rec[c];
            end
        end
        if (grant_idx == PTR_W'(NUM_CH - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = grant_idx + PTR_W'(1);
        end
    end

    // A stage accepts a new beat when empty or when it is being emptied this cycle.
    always_comb begin
        load_vec = '0;
        drop_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (en && in_valid[c]) begin
                if (!stage_full[c] || grant_vec[c]) begin
                    load_vec[c] = 1'b1;
                end else begin
                    drop_sum = drop_sum + 4'd1;
                end
            end
        end
        drop_wide = DSUM_W'(drop_q) + DSUM_W'(drop_sum);
        if (drop_wide > DSUM_W'({DROP_W{1'b1}})) begin
            drop_next = '1;
        end else begin
            drop_next = drop_wide[DROP_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stamp_q    <= '0;
            stage_full <= '0;
            rr_ptr     <= '0;
            drop_q     <= '0;
        end else begin
            stamp_q <= stamp_q + STAMP_W'(1);
            for (int c = 0; c < NUM_CH; c++) begin
                if (load_vec[c]) begin
                    stage_full[c] <= 1'b1;
                end else if (grant_vec[c]) begin
                    stage_full[c] <= 1'b0;
                end
            end
            if (push) begin
                rr_ptr <= rr_next;
            end
            drop_q <= drop_next;
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (load_vec[c]) begin
                stage_rec[c] <= cap_rec[c];
            end
        end
    end

    tl_log_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (push_rec),
        .pop        (pop),
        .head       (out_record),
        .head_valid (out_valid),
        .full       (fifo_full),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_tl_log_buffer.sv
// Directed bench for tl_log_buffer: latency, channel ordering, overflow, saturation, reset.
module tb_tl_log_buffer;

    localparam int NCH = 5;
    localparam int AW  = 64;
    localparam int DW  = 256;
    localparam int SW  = 64;

    typedef struct packed {
        logic [63:0]  stamp;
        logic [2:0]   ch;
        logic [7:0]   opcode;
        logic [7:0]   param;
        logic [7:0]   source;
        logic [7:0]   sink;
        logic [63:0]  addr;
        logic [255:0] data;
    } rec_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              en;
    logic              out_ready;
    logic [NCH-1:0]    in_valid;
    logic [NCH*8-1:0]  in_opcode;
    logic [NCH*8-1:0]  in_param;
    logic [NCH*8-1:0]  in_source;
    logic [NCH*8-1:0]  in_sink;
    logic [NCH*AW-1:0] in_address;
    logic [NCH*DW-1:0] in_data;

    logic              out_valid;
    logic [418:0]      out_record;
    logic [4:0]        fifo_count;
    logic [15:0]       drop_count;
    logic [63:0]       stamp_now;

    logic              sat_out_valid;
    logic [418:0]      sat_out_record;
    logic [4:0]        sat_fifo_count;
    logic [3:0]        sat_drop_count;
    logic [63:0]       sat_stamp_now;

    rec_t              head;
    int                total = 0;
    int                bad = 0;
    logic [63:0]       exp_stamp;
    int                exp_drop;

    assign head = rec_t'(out_record);

    tl_log_buffer dut (
        .clock(clock), .reset(reset), .en(en),
        .in_valid(in_valid), .in_opcode(in_opcode), .in_param(in_param),
        .in_source(in_source), .in_sink(in_sink), .in_address(in_address), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_record(out_record),
        .fifo_count(fifo_count), .drop_count(drop_count), .stamp_now(stamp_now)
    );

    tl_log_buffer #(.DROP_W(4)) dut_sat (
        .clock(clock), .reset(reset), .en(en),
        .in_valid(in_valid), .in_opcode(in_opcode), .in_param(in_param),
        .in_source(in_source), .in_sink(in_sink), .in_address(in_address), .in_data(in_data),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_record(sat_out_record),
        .fifo_count(sat_fifo_count), .drop_count(sat_drop_count), .stamp_now(sat_stamp_now)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clearInputs();
        in_valid   = '0;
        in_opcode  = '0;
        in_param   = '0;
        in_source  = '0;
        in_sink    = '0;
        in_address = '0;
        in_data    = '0;
    endtask

    task automatic applyStimulus(input int ch, input logic [7:0] opc, input logic [63:0] addr);
        in_valid[ch]               = 1'b1;
        in_opcode[ch*8 +: 8]       = opc;
        in_param[ch*8 +: 8]        = 8'h0;
        in_source[ch*8 +: 8]       = 8'(ch + 16);
        in_sink[ch*8 +: 8]         = 8'(ch + 32);
        in_address[ch*AW +: AW]    = addr;
        in_data[ch*DW +: DW]       = {4{addr ^ 64'hA5}};
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tickN(2);
        reset = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b1;
        out_ready = 1'b0;
        clearInputs();
        tickN(2);
        checkOutput("rst_stamp", stamp_now, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_drop", drop_count, 0);
        reset = 1'b0;

        // en=0 must block capture
        tickN(5);
        checkOutput("stamp_5", stamp_now, 5);
        en = 1'b0;
        applyStimulus(1, 8'h11, 64'h2000);
        tick();
        clearInputs();
        en = 1'b1;
        tick();
        checkOutput("en0_valid", out_valid, 0);
        checkOutput("en0_count", fifo_count, 0);

        // single beat at stamp 10
        tickN(3);
        checkOutput("stamp_10", stamp_now, 10);
        applyStimulus(0, 8'd4, 64'h1000);
        tick();
        clearInputs();
        checkOutput("t1_staged_not_out", out_valid, 0);
        tick();
        checkOutput("t1_valid", out_valid, 1);
        checkOutput("t1_stamp_now", stamp_now, 12);
        checkOutput("t1_rec_stamp", head.stamp, 10);
        checkOutput("t1_rec_ch", head.ch, 0);
        checkOutput("t1_rec_opcode", head.opcode, 4);
        checkOutput("t1_rec_addr", head.addr, 64'h1000);
        checkOutput("t1_rec_data", head.data, {4{64'h10A5}});
        checkOutput("t1_drop", drop_count, 0);
        out_ready = 1'b1;
        tick();
        checkOutput("t1_drained", out_valid, 0);

        // all channels in one cycle, pointer restarted at 0
        applyReset();
        tickN(3);
        for (int c = 0; c < NCH; c++) applyStimulus(c, 8'(c + 1), 64'h100 * c);
        tick();
        clearInputs();
        tick();
        for (int k = 0; k < NCH; k++) begin
            checkOutput($sformatf("t2_valid_%0d", k), out_valid, 1);
            checkOutput($sformatf("t2_ch_%0d", k), head.ch, k);
            checkOutput($sformatf("t2_opc_%0d", k), head.opcode, k + 1);
            checkOutput($sformatf("t2_src_%0d", k), head.source, k + 16);
            checkOutput($sformatf("t2_stamp_%0d", k), head.stamp, 3);
            tick();
        end
        checkOutput("t2_empty", out_valid, 0);
        checkOutput("t2_drop", drop_count, 0);

        // overflow on ch2 with consumer stalled
        applyReset();
        out_ready = 1'b0;
        tickN(2);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(2, 8'h40, 64'(i));
            tick();
            if (i == 16) begin
                checkOutput("t3_full_count", fifo_count, 16);
                checkOutput("t3_full_nodrop", drop_count, 0);
            end
        end
        clearInputs();
        checkOutput("t3_count", fifo_count, 16);
        checkOutput("t3_drop", drop_count, 3);
        checkOutput("t3_sat_drop", sat_drop_count, 3);
        checkOutput("t3_head_stamp", head.stamp, 2);
        tick();
        checkOutput("t3_hold_stamp", head.stamp, 2);
        checkOutput("t3_hold_addr", head.addr, 0);
        checkOutput("t3_hold_count", fifo_count, 16);
        checkOutput("t3_stamp_now", stamp_now, 23);

        // full FIFO and full stage: push+pop together, new beat is accepted
        out_ready = 1'b1;
        applyStimulus(2, 8'h41, 64'hBEEF);
        tick();
        clearInputs();
        checkOutput("t4_count", fifo_count, 16);
        checkOutput("t4_drop", drop_count, 3);
        for (int k = 1; k <= 17; k++) begin
            exp_stamp = (k <= 16) ? 64'(2 + k) : 64'd23;
            checkOutput($sformatf("t3_valid_%0d", k), out_valid, 1);
            checkOutput($sformatf("t3_stamp_%0d", k), head.stamp, exp_stamp);
            checkOutput($sformatf("t3_addr_%0d", k), head.addr, (k <= 16) ? 64'(k) : 64'hBEEF);
            tick();
        end
        checkOutput("t3_drained_valid", out_valid, 0);
        checkOutput("t3_drained_count", fifo_count, 0);

        // saturation: several channels dropping per cycle
        applyReset();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(2, 8'h50, 64'(i));
            tick();
        end
        checkOutput("t5_count", fifo_count, 16);
        checkOutput("t5_drop0", drop_count, 0);
        for (int j = 0; j < 5; j++) begin
            for (int c = 0; c < NCH; c++) applyStimulus(c, 8'h60, 64'(j));
            tick();
            exp_drop = 1 + 5 * j;
            checkOutput($sformatf("t5_drop_%0d", j), drop_count, exp_drop);
            checkOutput($sformatf("t5_sat_%0d", j), sat_drop_count, (exp_drop > 15) ? 15 : exp_drop);
        end
        clearInputs();

        // reset with 8 records queued
        out_ready = 1'b1;
        tickN(13);
        out_ready = 1'b0;
        checkOutput("t6_count8", fifo_count, 8);
        checkOutput("t6_drop_pre", drop_count, 21);
        reset = 1'b1;
        tick();
        checkOutput("t6_valid", out_valid, 0);
        checkOutput("t6_count", fifo_count, 0);
        checkOutput("t6_stamp", stamp_now, 0);
        checkOutput("t6_drop", drop_count, 0);
        checkOutput("t6_sat_drop", sat_drop_count, 0);
        reset = 1'b0;
        tick();
        checkOutput("t6_stamp_1", stamp_now, 1);
        checkOutput("t6_valid_after", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
